// File: rtl/rtr_systolic_mc_pkg.sv
// sys_rtr_pkg: shared helpers for the rtr_systolic_mc multicast router.
package sys_rtr_pkg;
    function automatic logic [31:0] bcast_id(input int w);
        return (32'd1 << w) - 32'd1;
    endfunction
    function automatic logic [31:0] popcount(input logic [31:0] v);
        logic [31:0] n;
        n = '0;
        for (int i = 0; i < 32; i++) n = n + {31'd0, v[i]};
        return n;
    endfunction
endpackage

// File: rtl/rtr_systolic_mc_if.sv
// rtr_systolic_mc_if: router bus; slave = router side, master = driver/observer side.
interface rtr_systolic_mc_if #(
    parameter int I_WIDTH    = 8,
    parameter int P_WIDTH    = 20,
    parameter int CTRL_WIDTH = 9,
    parameter int ID_WIDTH   = 4,
    parameter int N_CH       = 2,
    parameter int CNT_WIDTH  = 16
);
    logic                     stall_in;
    logic                     cfg_we;
    logic [ID_WIDTH-1:0]      cfg_id;
    logic [CTRL_WIDTH-1:0]    global_ctrl_in, global_ctrl_out, local_ctrl_out;
    logic [N_CH*I_WIDTH-1:0]  global_iact_in, global_iact_out, local_iact_out;
    logic [N_CH*ID_WIDTH-1:0] global_iact_tag_in, global_iact_tag_out;
    logic [N_CH-1:0]          global_iact_vld_in, global_iact_vld_out, local_iact_vld_out;
    logic [P_WIDTH-1:0]       global_psum_in, local_psum_out, local_psum_in, global_psum_out;
    logic                     global_psum_vld_in, local_psum_vld_in, global_psum_vld_out;
    logic                     psum_collision;
    logic [CNT_WIDTH-1:0]     dlv_count;
    logic [ID_WIDTH-1:0]      my_id;
    modport slave (
        input  stall_in, cfg_we, cfg_id, global_ctrl_in, global_iact_in, global_iact_tag_in,
               global_iact_vld_in, global_psum_in, global_psum_vld_in, local_psum_in, local_psum_vld_in,
        output global_ctrl_out, local_ctrl_out, global_iact_out, local_iact_out, global_iact_tag_out,
               global_iact_vld_out, local_iact_vld_out, local_psum_out, global_psum_out,
               global_psum_vld_out, psum_collision, dlv_count, my_id
    );
    modport master (
        output stall_in, cfg_we, cfg_id, global_ctrl_in, global_iact_in, global_iact_tag_in,
               global_iact_vld_in, global_psum_in, global_psum_vld_in, local_psum_in, local_psum_vld_in,
        input  global_ctrl_out, local_ctrl_out, global_iact_out, local_iact_out, global_iact_tag_out,
               global_iact_vld_out, local_iact_vld_out, local_psum_out, global_psum_out,
               global_psum_vld_out, psum_collision, dlv_count, my_id
    );
endinterface

// File: rtl/rtr_systolic_mc_stall_pipe.sv
// rtr_stall_pipe: generic async-reset shift register that advances only when i_en is high.
module rtr_stall_pipe #(
    parameter int W     = 8,
    parameter int DEPTH = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_en,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);
    logic [W-1:0] r_stage [DEPTH];
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) r_stage[i] <= '0;
        end else if (i_en) begin
            r_stage[0] <= i_d;
            for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
        end
    end
    assign o_q = r_stage[DEPTH-1];
endmodule

// File: rtl/rtr_systolic_mc.sv
// rtr_systolic_mc: multicast router for one systolic PE slot (forward pipe, tag delivery, psum merge).
// Define RTR_PSUM_REG_EN to register the merged psum output.
module rtr_systolic_mc
    import sys_rtr_pkg::*;
#(
    parameter int I_WIDTH    = 8,
    parameter int P_WIDTH    = 20,
    parameter int CTRL_WIDTH = 9,
    parameter int ID_WIDTH   = 4,
    parameter int N_CH       = 2,
    parameter int FWD_DEPTH  = 1,
    parameter int CNT_WIDTH  = 16
) (
    input logic               clk,
    input logic               rst,
    rtr_systolic_mc_if.slave  bus
);
    localparam logic [ID_WIDTH-1:0] BCAST = ID_WIDTH'(bcast_id(ID_WIDTH));

    typedef struct packed {
        logic [CTRL_WIDTH-1:0]    ctrl;
        logic [N_CH*I_WIDTH-1:0]  iact;
        logic [N_CH*ID_WIDTH-1:0] tag;
        logic [N_CH-1:0]          vld;
    } fwd_stage_t;

    fwd_stage_t           w_fwd_in, w_fwd_out;
    logic                 w_adv;
    logic [N_CH-1:0]      w_dlv;
    logic [CNT_WIDTH:0]   w_cnt_sum;
    logic [P_WIDTH-1:0]   w_psum;
    logic                 w_pvld;
    logic [ID_WIDTH-1:0]  r_id;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic                 r_col;

    assign w_adv    = !bus.stall_in;
    assign w_fwd_in = '{ctrl: bus.global_ctrl_in, iact: bus.global_iact_in,
                        tag: bus.global_iact_tag_in, vld: bus.global_iact_vld_in};

    rtr_stall_pipe #(.W($bits(fwd_stage_t)), .DEPTH(FWD_DEPTH)) u_pipe (
        .clk  (clk),
        .rst  (rst),
        .i_en (w_adv),
        .i_d  (w_fwd_in),
        .o_q  (w_fwd_out)
    );

    assign bus.global_ctrl_out     = w_fwd_out.ctrl;
    assign bus.global_iact_out     = w_fwd_out.iact;
    assign bus.global_iact_tag_out = w_fwd_out.tag;
    assign bus.global_iact_vld_out = w_fwd_out.vld;
    assign bus.local_ctrl_out      = bus.global_ctrl_in;
    assign bus.local_iact_out      = bus.global_iact_in;
    assign bus.local_psum_out      = bus.global_psum_in;

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        logic [ID_WIDTH-1:0] w_tag;
        assign w_tag    = bus.global_iact_tag_in[c*ID_WIDTH +: ID_WIDTH];
        assign w_dlv[c] = bus.global_iact_vld_in[c] & w_adv & (w_tag == r_id | w_tag == BCAST);
    end

    assign bus.local_iact_vld_out = w_dlv;
    assign w_cnt_sum = {1'b0, r_cnt} + (CNT_WIDTH+1)'(popcount(32'(w_dlv)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_id  <= '0;
            r_cnt <= '0;
            r_col <= 1'b0;
        end else begin
            if (bus.cfg_we && bus.cfg_id != BCAST) r_id <= bus.cfg_id;
            r_cnt <= w_cnt_sum[CNT_WIDTH] ? '1 : w_cnt_sum[CNT_WIDTH-1:0];
            // a config write acknowledges the collision flag and takes priority over a new hit
            if (bus.cfg_we) r_col <= 1'b0;
            else if (w_adv && bus.local_psum_vld_in && bus.global_psum_vld_in) r_col <= 1'b1;
        end
    end

    assign bus.my_id          = r_id;
    assign bus.dlv_count      = r_cnt;
    assign bus.psum_collision = r_col;
    assign w_psum = bus.local_psum_vld_in ? bus.local_psum_in : bus.global_psum_in;
    assign w_pvld = bus.local_psum_vld_in | bus.global_psum_vld_in;

`ifdef RTR_PSUM_REG_EN
    logic [P_WIDTH-1:0] r_psum;
    logic               r_pvld;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_psum <= '0;
            r_pvld <= 1'b0;
        end else if (w_adv) begin
            r_psum <= w_psum;
            r_pvld <= w_pvld;
        end
    end
    assign bus.global_psum_out     = r_psum;
    assign bus.global_psum_vld_out = r_pvld;
`else
    assign bus.global_psum_out     = w_psum;
    assign bus.global_psum_vld_out = w_pvld;
`endif
endmodule

// File: tb/tb_rtr_systolic_mc.sv
// tb_rtr_systolic_mc: scoreboard bench for rtr_systolic_mc (N_CH=2, FWD_DEPTH=2, CNT_WIDTH=4).
module tb_rtr_systolic_mc;
    localparam int IW = 8, PW = 20, CW = 9, ID = 4, NC = 2, FD = 2, CNTW = 4;
    localparam int CMAX = (1 << CNTW) - 1;
    localparam logic [ID-1:0] BC = {ID{1'b1}};

    typedef struct {
        logic stall, cfg_we;
        logic [ID-1:0] cfg_id;
        logic [CW-1:0] ctrl;
        logic [NC*IW-1:0] iact;
        logic [NC*ID-1:0] tag;
        logic [NC-1:0] vld;
        logic [PW-1:0] gp, lp;
        logic gv, lv;
    } stim_t;
    typedef struct { logic [IW-1:0] d; logic [ID-1:0] t; logic [CW-1:0] ctrl; int ts; } fwd_t;
    typedef struct { logic [NC-1:0] dlv; int cnt; logic col; logic [ID-1:0] id; logic [PW-1:0] ps; logic pv; stim_t s; } loc_t;

    logic clk = 1'b0, rst = 1'b1;
    always #5 clk = ~clk;

    rtr_systolic_mc_if #(.I_WIDTH(IW), .P_WIDTH(PW), .CTRL_WIDTH(CW), .ID_WIDTH(ID), .N_CH(NC), .CNT_WIDTH(CNTW)) bus ();
    rtr_systolic_mc #(.I_WIDTH(IW), .P_WIDTH(PW), .CTRL_WIDTH(CW), .ID_WIDTH(ID), .N_CH(NC),
                      .FWD_DEPTH(FD), .CNT_WIDTH(CNTW)) dut (.clk(clk), .rst(rst), .bus(bus));

    int errors = 0, checks = 0, adv_cnt = 0;
    fwd_t fq[NC][$];
    loc_t lq[$];
    stim_t p;
    logic [ID-1:0] m_id;
    int m_cnt;
    logic m_col;
`ifdef RTR_PSUM_REG_EN
    logic [PW-1:0] m_preg;
    logic m_pvld;
`endif

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", n, a, e);
        end
    endtask

    function automatic stim_t idle();
        stim_t s;
        s = '{default: '0};
        return s;
    endfunction

    // a channel is delivered when valid, not stalled, and addressed to this ID or to everyone
    function automatic logic [NC-1:0] deliver(input stim_t s, input logic [ID-1:0] id);
        logic [NC-1:0] r;
        for (int c = 0; c < NC; c++)
            r[c] = s.vld[c] && !s.stall && (s.tag[c*ID +: ID] == id || s.tag[c*ID +: ID] == BC);
        return r;
    endfunction

    task automatic model_edge();
        logic [NC-1:0] d;
        d = deliver(p, m_id);
        if (!p.stall) adv_cnt++;
        m_cnt = (m_cnt + $countones(d) > CMAX) ? CMAX : m_cnt + $countones(d);
        m_col = p.cfg_we ? 1'b0 : (!p.stall && p.gv && p.lv) ? 1'b1 : m_col;
        if (p.cfg_we && p.cfg_id != BC) m_id = p.cfg_id;
`ifdef RTR_PSUM_REG_EN
        if (!p.stall) begin
            m_preg = p.lv ? p.lp : p.gp;
            m_pvld = p.lv | p.gv;
        end
`endif
    endtask

    task automatic drive(input stim_t s);
        bus.stall_in = s.stall; bus.cfg_we = s.cfg_we; bus.cfg_id = s.cfg_id;
        bus.global_ctrl_in = s.ctrl; bus.global_iact_in = s.iact;
        bus.global_iact_tag_in = s.tag; bus.global_iact_vld_in = s.vld;
        bus.global_psum_in = s.gp; bus.global_psum_vld_in = s.gv;
        bus.local_psum_in = s.lp; bus.local_psum_vld_in = s.lv;
    endtask

    task automatic apply(input stim_t s);
        loc_t e;
        fwd_t f;
        drive(s);
        p = s;
        e.s = s; e.dlv = deliver(s, m_id); e.cnt = m_cnt; e.col = m_col; e.id = m_id;
`ifdef RTR_PSUM_REG_EN
        e.ps = m_preg; e.pv = m_pvld;
`else
        e.ps = s.lv ? s.lp : s.gp; e.pv = s.lv | s.gv;
`endif
        lq.push_back(e);
        if (!s.stall)
            for (int c = 0; c < NC; c++)
                if (s.vld[c]) begin
                    f.d = s.iact[c*IW +: IW]; f.t = s.tag[c*ID +: ID]; f.ctrl = s.ctrl; f.ts = adv_cnt;
                    fq[c].push_back(f);
                end
    endtask

    task automatic cycle(input stim_t s);
        @(posedge clk);
        model_edge();
        #1;
        apply(s);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3;
        drive(idle());
        rst = 1'b1;
        #1;
        chk("rst_fwd_vld", bus.global_iact_vld_out, 0);
        chk("rst_fwd_data", {bus.global_ctrl_out, bus.global_iact_out, bus.global_iact_tag_out}, 0);
        chk("rst_psum_vld", bus.global_psum_vld_out, 0);
        chk("rst_cnt", bus.dlv_count, 0);
        chk("rst_id_col", {bus.my_id, bus.psum_collision}, 0);
        lq.delete();
        for (int c = 0; c < NC; c++) fq[c].delete();
        m_id = '0; m_cnt = 0; m_col = 1'b0; p = idle();
`ifdef RTR_PSUM_REG_EN
        m_preg = '0; m_pvld = 1'b0;
`endif
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;
    endtask

    always @(negedge clk) begin : mon
        loc_t e;
        logic ev;
        if (!rst) begin
            if (lq.size() == 0) begin
                checks++; errors++;
                $display("FAIL loc_sb: no expected entry");
            end else begin
                e = lq.pop_front();
                chk("dlv_vld", bus.local_iact_vld_out, e.dlv);
                chk("dlv_count", bus.dlv_count, e.cnt);
                chk("collision", bus.psum_collision, e.col);
                chk("my_id", bus.my_id, e.id);
                chk("psum_out", bus.global_psum_out, e.ps);
                chk("psum_vld", bus.global_psum_vld_out, e.pv);
                chk("local_pass", {bus.local_ctrl_out, bus.local_iact_out, bus.local_psum_out}, {e.s.ctrl, e.s.iact, e.s.gp});
            end
            for (int c = 0; c < NC; c++) begin
                ev = 1'b0;
                if (fq[c].size() > 0) ev = (fq[c][0].ts + FD == adv_cnt);
                chk($sformatf("fwd_vld%0d", c), bus.global_iact_vld_out[c], ev);
                if (ev && bus.global_iact_vld_out[c]) begin
                    chk($sformatf("fwd_data%0d", c), bus.global_iact_out[c*IW +: IW], fq[c][0].d);
                    chk($sformatf("fwd_tag%0d", c), bus.global_iact_tag_out[c*ID +: ID], fq[c][0].t);
                    chk($sformatf("fwd_ctrl%0d", c), bus.global_ctrl_out, fq[c][0].ctrl);
                end
                if (ev && !bus.stall_in) void'(fq[c].pop_front());
            end
        end
    end

    initial begin
        stim_t s;
        drive(idle());
        do_reset();
        // id 3, ch0 addressed to us, ch1 elsewhere
        s = idle(); s.cfg_we = 1'b1; s.cfg_id = 4'd3; cycle(s);
        s = idle(); s.vld = 2'b11; s.tag = {4'd7, 4'd3}; s.iact = {8'hC3, 8'h5A}; s.ctrl = 9'h1AB; cycle(s);
        #1 chk("t1_dlv", bus.local_iact_vld_out, 2'b01);
        cycle(idle()); cycle(idle());
        #1 chk("t1_cnt", bus.dlv_count, 1);
        chk("t1_out", {bus.global_iact_vld_out, bus.global_iact_out}, {2'b11, 16'hC35A});
        // broadcast, then a write of the reserved ID
        s = idle(); s.vld = 2'b11; s.tag = 8'hFF; cycle(s);
        #1 chk("t2_dlv", bus.local_iact_vld_out, 2'b11);
        s = idle(); s.cfg_we = 1'b1; s.cfg_id = BC; cycle(s);
        #1 chk("t2_cnt", bus.dlv_count, 3);
        cycle(idle());
        #1 chk("t2_id", bus.my_id, 3);
        // four valids with a three-cycle stall in the middle
        for (int i = 0; i < 7; i++) begin
            s = idle(); s.stall = (i >= 2 && i < 5); s.vld = 2'b01; s.tag = 8'h03; s.iact = 16'(i + 1); s.ctrl = 9'(i);
            cycle(s);
            if (s.stall) #1 chk("t3_stall_dlv", bus.local_iact_vld_out, 0);
        end
        repeat (FD + 1) cycle(idle());
        // psum collision
        s = idle(); s.gv = 1'b1; s.gp = 20'h00456; s.lv = 1'b1; s.lp = 20'h00123; cycle(s);
`ifndef RTR_PSUM_REG_EN
        #1 chk("t4_psum", bus.global_psum_out, 20'h00123);
`endif
        s = idle(); s.stall = 1'b1; cycle(s);
        #1 chk("t4_col", bus.psum_collision, 1);
`ifdef RTR_PSUM_REG_EN
        chk("t6_psum", bus.global_psum_out, 20'h00123);
        cycle(s);
        #1 chk("t6_hold", {bus.global_psum_vld_out, bus.global_psum_out}, {1'b1, 20'h00123});
`endif
        s = idle(); s.cfg_we = 1'b1; s.cfg_id = 4'd3; cycle(s);
        cycle(idle());
        #1 chk("t4_clr", bus.psum_collision, 0);
        // saturation of the delivery counter
        do_reset();
        s = idle(); s.vld = 2'b11; s.tag = 8'hFF;
        repeat (7) cycle(s);
        cycle(idle());
        #1 chk("t5_14", bus.dlv_count, 14);
        s.vld = 2'b01;
        repeat (3) cycle(s);
        cycle(idle());
        #1 chk("t5_sat", bus.dlv_count, 15);
        s.vld = 2'b11; cycle(s); cycle(s);
        do_reset();
        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            s.stall = ($urandom_range(0, 4) == 0);
            s.cfg_we = ($urandom_range(0, 19) == 0);
            s.cfg_id = ID'($urandom);
            s.ctrl = CW'($urandom);
            s.iact = (NC*IW)'($urandom);
            for (int c = 0; c < NC; c++) begin
                case ($urandom_range(0, 3))
                    0: s.tag[c*ID +: ID] = m_id;
                    1: s.tag[c*ID +: ID] = BC;
                    default: s.tag[c*ID +: ID] = ID'($urandom);
                endcase
            end
            s.vld = NC'($urandom);
            s.gp = PW'($urandom); s.lp = PW'($urandom);
            s.gv = 1'($urandom); s.lv = 1'($urandom);
            cycle(s);
            if (i == 200) do_reset();
        end
        repeat (FD + 2) cycle(idle());
        @(negedge clk);
        #1;
        for (int c = 0; c < NC; c++) chk($sformatf("drain%0d", c), fq[c].size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
